// File: rtl/discrete_pkg.sv
// Shared types and arithmetic helpers for the discrete sound-effect voices.
// Helpers work on 32-bit signed values so any voice width up to 30 bits can use them.
package discrete_pkg;

  localparam int SIGNAL_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    ENV_IDLE,
    ENV_ATTACK,
    ENV_HOLD,
    ENV_DECAY
  } env_state_t;

  // Envelope ceiling leaves two bits of headroom for the DC block and output gain.
  function automatic int env_max(input int sw);
    return (1 << (sw - 2)) - 1;
  endfunction

  function automatic logic signed [31:0] apply_gain(input logic signed [31:0] y,
                                                    input int pos_q2,
                                                    input int neg_q2);
    logic signed [31:0] p;
    p = (y > 0) ? y * pos_q2 : y * neg_q2;
    return p >>> 2;
  endfunction

  function automatic logic signed [31:0] saturate(input logic signed [31:0] v,
                                                  input int sw);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (1 <<< (sw - 1)) - 1;
    lo = -(1 <<< (sw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/ar_envelope_generator.sv
// Trigger-gated attack/release envelope; state and level advance once per audio strobe.
//  state      | meaning
//  ENV_IDLE   | silent, env held at 0
//  ENV_ATTACK | rising by ATTACK_STEP toward ENV_MAX
//  ENV_HOLD   | at ENV_MAX while the gate stays high
//  ENV_DECAY  | falling by DECAY_STEP toward 0; a new gate re-attacks from the current level
module ar_envelope_generator
  import discrete_pkg::*;
#(
  parameter int SW          = SIGNAL_WIDTH_DEFAULT,
  parameter int ATTACK_STEP = 512,
  parameter int DECAY_STEP  = 16
) (
  input  logic          clk,
  input  logic          I_RSTn,
  input  logic          audio_clk_en,
  input  logic          trigger,
  output logic [SW-1:0] env,
  output logic          active
);

  localparam logic [SW:0] MAX_E = (SW + 1)'(env_max(SW));
  localparam logic [SW:0] ATT_E = (SW + 1)'(ATTACK_STEP);
  localparam logic [SW:0] DEC_E = (SW + 1)'(DECAY_STEP);

  env_state_t    state;
  env_state_t    state_next;
  logic [SW:0]   env_ext;
  logic [SW:0]   rise;
  logic          at_top;
  logic          at_floor;
  logic [SW-1:0] env_d;

  assign env_ext  = {1'b0, env};
  assign rise     = env_ext + ATT_E;
  assign at_top   = (rise >= MAX_E);
  assign at_floor = (env_ext <= DEC_E);

  always_ff @(posedge clk) begin
    if (!I_RSTn) begin
      state <= ENV_IDLE;
      env   <= '0;
    end else if (audio_clk_en) begin
      state <= state_next;
      env   <= env_d;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ENV_IDLE:   if (trigger) state_next = ENV_ATTACK;
      ENV_ATTACK: begin
        if (!trigger)    state_next = ENV_DECAY;
        else if (at_top) state_next = ENV_HOLD;
      end
      ENV_HOLD:   if (!trigger) state_next = ENV_DECAY;
      ENV_DECAY: begin
        if (trigger)       state_next = ENV_ATTACK;
        else if (at_floor) state_next = ENV_IDLE;
      end
      default:    state_next = ENV_IDLE;
    endcase
  end

  // The level applied on a strobe is the one belonging to the state being entered.
  always_comb begin
    env_d = env;
    case (state_next)
      ENV_IDLE:   env_d = '0;
      ENV_ATTACK: env_d = at_top ? MAX_E[SW-1:0] : rise[SW-1:0];
      ENV_HOLD:   env_d = MAX_E[SW-1:0];
      ENV_DECAY:  env_d = at_floor ? '0 : env - DEC_E[SW-1:0];
      default:    env_d = '0;
    endcase
    active = (state != ENV_IDLE);
  end

endmodule

// File: rtl/gated_vco_voice.sv
// One discrete voice: gated AR envelope on an LFO-modulated pulse VCO,
// followed by a DC-blocking high-pass and asymmetric output gain.
module gated_vco_voice
  import discrete_pkg::*;
#(
  parameter int                     SIGNAL_WIDTH = SIGNAL_WIDTH_DEFAULT,
  parameter int                     PHASE_WIDTH  = 24,
  parameter logic [PHASE_WIDTH-1:0] BASE_INC     = PHASE_WIDTH'(5000),
  parameter logic [PHASE_WIDTH-1:0] DEV_INC      = PHASE_WIDTH'(1200),
  parameter logic [PHASE_WIDTH-1:0] INC_SLEW     = PHASE_WIDTH'(40),
  parameter logic [7:0]             DUTY         = 8'd160,
  parameter int                     LFO_HALF     = 2400,
  parameter int                     ATTACK_STEP  = 512,
  parameter int                     DECAY_STEP   = 16,
  parameter int                     HP_SHIFT     = 6,
  parameter int                     POS_GAIN_Q2  = 6,
  parameter int                     NEG_GAIN_Q2  = 3
) (
  input  logic                           clk,
  input  logic                           I_RSTn,
  input  logic                           audio_clk_en,
  input  logic                           trigger,
  output logic                           env_active,
  output logic signed [SIGNAL_WIDTH-1:0] out
);

  localparam int SW = SIGNAL_WIDTH;
  localparam int PW = PHASE_WIDTH;
  localparam int XW = SW + 2;
  localparam int CW = (LFO_HALF > 1) ? $clog2(LFO_HALF) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LFO_HALF - 1);

  logic [SW-1:0]        env;
  logic [PW-1:0]        phase;
  logic [PW-1:0]        phase_d;
  logic [PW-1:0]        inc;
  logic [PW-1:0]        inc_d;
  logic [PW-1:0]        target;
  logic [PW-1:0]        step_up;
  logic [PW-1:0]        step_dn;
  logic                 lfo;
  logic [CW-1:0]        lfo_cnt;
  logic                 pulse;
  logic signed [XW-1:0] x;
  logic signed [XW-1:0] x_prev;
  logic signed [XW-1:0] y;
  logic signed [XW-1:0] y_d;
  logic signed [31:0]   g;
  logic signed [SW-1:0] out_d;

  ar_envelope_generator #(
    .SW          (SW),
    .ATTACK_STEP (ATTACK_STEP),
    .DECAY_STEP  (DECAY_STEP)
  ) u_env (
    .clk          (clk),
    .I_RSTn       (I_RSTn),
    .audio_clk_en (audio_clk_en),
    .trigger      (trigger),
    .env          (env),
    .active       (env_active)
  );

  // Increment slews toward the LFO target like an RC-filtered control voltage.
  always_comb begin
    target  = BASE_INC + (lfo ? DEV_INC : '0);
    step_up = target - inc;
    step_dn = inc - target;
    inc_d   = inc;
    if (target > inc)
      inc_d = inc + ((step_up > INC_SLEW) ? INC_SLEW : step_up);
    else if (target < inc)
      inc_d = inc - ((step_dn > INC_SLEW) ? INC_SLEW : step_dn);
    phase_d = phase + inc_d;
  end

  assign pulse = (phase[PW-1 -: 8] < DUTY);
  assign x     = pulse ? signed'({2'b00, env}) : '0;
  assign y_d   = x - x_prev + y - (y >>> HP_SHIFT);
  assign g     = apply_gain(32'(y_d), POS_GAIN_Q2, NEG_GAIN_Q2);
  assign out_d = SW'(saturate(g, SW));

  always_ff @(posedge clk) begin
    if (!I_RSTn) begin
      phase   <= '0;
      inc     <= BASE_INC;
      lfo     <= 1'b0;
      lfo_cnt <= '0;
      x_prev  <= '0;
      y       <= '0;
      out     <= '0;
    end else if (audio_clk_en) begin
      phase  <= phase_d;
      inc    <= inc_d;
      x_prev <= x;
      y      <= y_d;
      out    <= out_d;
      if (lfo_cnt == CNT_LAST) begin
        lfo_cnt <= '0;
        lfo     <= ~lfo;
      end else begin
        lfo_cnt <= lfo_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gated_vco_voice.sv
// Bench for gated_vco_voice: per-cycle comparison against a behavioural voice model
// plus directed literal checks on envelope timing, LFO slew and the gain curve.
module tb_gated_vco_voice;
  import discrete_pkg::*;

  localparam int ENVMAX = 16383;
  localparam int A_STEP = 512;
  localparam int D_STEP = 16;
  localparam int BASE   = 5000;
  localparam int DEV    = 200;
  localparam int SLEW   = 40;
  localparam int DUTYV  = 160;
  localparam int HALF   = 4;
  localparam int HP     = 6;

  localparam int M_IDLE = 10;
  localparam int M_UP   = 11;
  localparam int M_TOP  = 12;
  localparam int M_DOWN = 13;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic trig = 1'b0;
  logic env_active;
  logic signed [15:0] out_s;

  int errors = 0;
  int checks = 0;
  bit cmp_on = 1'b0;

  int m_mode, m_env, m_phase, m_inc, m_lfo, m_cnt, m_xp, m_y, m_out;

  gated_vco_voice #(
    .LFO_HALF (HALF),
    .DEV_INC  (24'd200)
  ) dut (
    .clk          (clk),
    .I_RSTn       (rst_n),
    .audio_clk_en (en),
    .trigger      (trig),
    .env_active   (env_active),
    .out          (out_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural voice: one sample per strobe, outputs from the previous sample's env/phase.
  always @(posedge clk) begin
    int x, y, g, tgt;
    if (!rst_n) begin
      m_mode = M_IDLE; m_env = 0; m_phase = 0; m_inc = BASE;
      m_lfo = 0; m_cnt = 0; m_xp = 0; m_y = 0; m_out = 0;
    end else if (en) begin
      x = (((m_phase >> 16) & 255) < DUTYV) ? m_env : 0;
      y = x - m_xp + m_y - (m_y >>> HP);
      m_xp = x;
      m_y = y;
      g = (y > 0) ? (y * 6) >>> 2 : (y * 3) >>> 2;
      m_out = (g > 32767) ? 32767 : (g < -32768) ? -32768 : g;

      if (trig && m_mode != M_TOP) begin
        m_mode = M_UP;
        m_env = m_env + A_STEP;
        if (m_env >= ENVMAX) begin
          m_env = ENVMAX;
          if (m_mode == M_UP && x >= 0) m_mode = M_UP;
        end
      end else if (!trig && m_mode != M_IDLE) begin
        m_mode = M_DOWN;
        m_env = m_env - D_STEP;
        if (m_env <= 0) begin
          m_env = 0;
          m_mode = M_IDLE;
        end
      end
      if (m_mode == M_UP && m_env == ENVMAX) m_mode = M_TOP;

      tgt = BASE + (m_lfo ? DEV : 0);
      if (tgt > m_inc) m_inc += (tgt - m_inc > SLEW) ? SLEW : tgt - m_inc;
      else if (tgt < m_inc) m_inc -= (m_inc - tgt > SLEW) ? SLEW : m_inc - tgt;
      m_phase = (m_phase + m_inc) % (1 << 24);
      m_cnt++;
      if (m_cnt == HALF) begin
        m_cnt = 0;
        m_lfo = 1 - m_lfo;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("out", int'(out_s), m_out);
      chk("env_active", int'(env_active), (m_mode != M_IDLE) ? 1 : 0);
      chk("env", int'(dut.u_env.env), m_env);
      chk("inc", int'(dut.inc), m_inc);
    end
  end

  task automatic strobe(input logic t, input int gap);
    trig = t;
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (gap - 1) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    // Reset held with strobes and gate active
    rst_n = 1'b0; en = 1'b1; trig = 1'b1;
    @(posedge clk); #1;
    cmp_on = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", int'(out_s), 0);
    chk("rst_active", int'(env_active), 0);
    chk("rst_env", int'(dut.u_env.env), 0);
    chk("rst_inc", int'(dut.inc), 5000);
    chk("rst_phase", int'(dut.phase), 0);
    chk("rst_lfo", int'(dut.lfo), 0);
    rst_n = 1'b1; en = 1'b0;
    @(posedge clk); #1;

    // Attack with widely gapped strobes, LFO slew observed along the way
    for (int s = 1; s <= 32; s++) begin
      strobe(1'b1, 20);
      if (s == 1)  chk("att_env_s1", int'(dut.u_env.env), 512);
      if (s == 1)  chk("att_out_s1", int'(out_s), 0);
      if (s == 2)  chk("att_out_s2", int'(out_s), 768);
      if (s == 3)  chk("att_out_s3", int'(out_s), 1524);
      if (s == 4)  chk("lfo_s4", int'(dut.lfo), 1);
      if (s == 5)  chk("inc_s5", int'(dut.inc), 5040);
      if (s == 8)  chk("inc_s8", int'(dut.inc), 5160);
      if (s == 8)  chk("lfo_s8", int'(dut.lfo), 0);
      if (s == 9)  chk("inc_s9", int'(dut.inc), 5120);
      if (s == 31) chk("att_env_s31", int'(dut.u_env.env), 15872);
      if (s == 31) chk("att_state_s31", int'(dut.u_env.state), int'(ENV_ATTACK));
      if (s == 32) chk("att_env_s32", int'(dut.u_env.env), 16383);
      if (s == 32) chk("att_state_s32", int'(dut.u_env.state), int'(ENV_HOLD));
    end

    // Release from HOLD, then retrigger from the decayed level
    for (int k = 1; k <= 524; k++) begin
      strobe(1'b0, 2);
      if (k == 1) chk("dec_env_k1", int'(dut.u_env.env), 16367);
      if (k == 1) chk("dec_state_k1", int'(dut.u_env.state), int'(ENV_DECAY));
    end
    chk("dec_env_k524", int'(dut.u_env.env), 7999);
    strobe(1'b1, 2);
    chk("retrig_env", int'(dut.u_env.env), 8511);
    chk("retrig_state", int'(dut.u_env.state), int'(ENV_ATTACK));
    repeat (15) strobe(1'b1, 2);
    chk("retrig_env_15", int'(dut.u_env.env), 16191);
    strobe(1'b1, 2);
    chk("retrig_env_16", int'(dut.u_env.env), 16383);
    chk("retrig_state_16", int'(dut.u_env.state), int'(ENV_HOLD));

    // Gain curve and saturation
    chk("gain_pos_sat", int'(saturate(apply_gain(32'sd30000, 6, 3), 16)), 32767);
    chk("gain_neg", int'(saturate(apply_gain(-32'sd20000, 6, 3), 16)), -15000);
    chk("gain_pos", int'(saturate(apply_gain(32'sd1000, 6, 3), 16)), 1500);
    chk("gain_neg_sat", int'(saturate(apply_gain(-32'sd60000, 6, 3), 16)), -32768);

    // Reset in the middle of a held note
    rst_n = 1'b0; en = 1'b1; trig = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_out", int'(out_s), 0);
    chk("mid_rst_active", int'(env_active), 0);
    chk("mid_rst_env", int'(dut.u_env.env), 0);
    rst_n = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    repeat (2) strobe(1'b0, 2);
    chk("idle_active", int'(env_active), 0);
    strobe(1'b1, 2);
    chk("restart_env", int'(dut.u_env.env), 512);
    strobe(1'b0, 2);
    chk("short_rel_env", int'(dut.u_env.env), 496);
    repeat (30) strobe(1'b0, 2);
    chk("floor_env16", int'(dut.u_env.env), 16);
    chk("floor_active", int'(env_active), 1);
    strobe(1'b0, 2);
    chk("floor_env0", int'(dut.u_env.env), 0);
    chk("floor_idle", int'(env_active), 0);

    // Long run through the pulse low phase with a repeating gate pattern
    for (int i = 0; i < 2300; i++) begin
      strobe(((i % 400) < 330) ? 1'b1 : 1'b0, 2);
    end
    chk("long_pulse_low", int'(dut.phase >= 24'd10485760 || dut.phase < 24'd200000), 1);

    @(negedge clk);
    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
